// File: rtl/ps2_move_decoder.sv
// ps2_move_decoder: PS/2 receiver turning arrow-key and S-key makes into one-cycle pulses.
// Define PS2_PARITY_CHECK_EN to drop frames failing odd parity.
module ps2_move_decoder #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [3:0] direction,
  output logic       start,
  output logic       frame_err
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic          r_clk_prev;
  logic [1:0]    r_state;
  logic [7:0]    r_shift;
  logic [2:0]    r_cnt;
  logic          r_par;
  logic [TW-1:0] r_timer;
  logic          r_ext, r_brk;
  logic [4:0]    r_held;
  logic          w_clk, w_dat, w_fall, w_par_ok, w_good, w_timeout;
  logic [4:0]    w_key, w_new;
  assign w_clk  = r_clk_sync[SYNC_STAGES-1];
  assign w_dat  = r_dat_sync[SYNC_STAGES-1];
  assign w_fall = r_clk_prev & ~w_clk;
`ifdef PS2_PARITY_CHECK_EN
  assign w_par_ok = ^{r_shift, r_par};
`else
  assign w_par_ok = 1'b1;
`endif
  assign w_good    = w_dat & w_par_ok;
  assign w_timeout = (r_state != IDLE) && !w_fall && (r_timer == TMAX);
  // Key slots: [4] S, [3] up, [2] down, [1] left, [0] right; keypad codes lack the E0 prefix
  assign w_key = {~r_ext & (r_shift == 8'h1B),
                  r_ext & (r_shift == 8'h75),
                  r_ext & (r_shift == 8'h72),
                  r_ext & (r_shift == 8'h6B),
                  r_ext & (r_shift == 8'h74)};
  assign w_new = r_brk ? 5'b0 : (w_key & ~r_held);
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_par      <= 1'b0;
      r_timer    <= '0;
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_held     <= '0;
      direction  <= '0;
      start      <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], PS2_CLK};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], PS2_DAT};
      r_clk_prev <= w_clk;
      direction  <= '0;
      start      <= 1'b0;
      frame_err  <= 1'b0;
      r_timer    <= (r_state == IDLE || w_fall) ? '0 : r_timer + 1'b1;
      if (w_timeout) begin
        r_state   <= IDLE;
        frame_err <= 1'b1;
        r_ext     <= 1'b0;
        r_brk     <= 1'b0;
      end else if (w_fall) begin
        case (r_state)
          IDLE: if (!w_dat) begin
            r_state <= DATA;
            r_cnt   <= '0;
          end
          DATA: begin
            r_shift <= {w_dat, r_shift[7:1]};
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == 3'd7) r_state <= PARITY;
          end
          PARITY: begin
            r_par   <= w_dat;
            r_state <= STOP;
          end
          default: begin
            r_state <= IDLE;
            if (!w_good) frame_err <= 1'b1;
            else if (r_shift == 8'hE0) r_ext <= 1'b1;
            else if (r_shift == 8'hF0) r_brk <= 1'b1;
            else begin
              direction <= w_new[3:0];
              start     <= w_new[4];
              r_held    <= r_brk ? (r_held & ~w_key) : (r_held | w_key);
              r_ext     <= 1'b0;
              r_brk     <= 1'b0;
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ps2_move_decoder.sv
// tb_ps2_move_decoder: directed PS/2 frames with hand-computed pulse counts and latency.
module tb_ps2_move_decoder;
  localparam int TO   = 200;
  localparam int HALF = 6;
  logic       CLOCK_50 = 1'b0;
  logic       resetn   = 1'b0;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic [3:0] direction;
  logic       start;
  logic       frame_err;
  int total = 0, bad = 0;
  int cyc = 0, t_stop = 0, t_dir = 0;
  int dir_cnt = 0, st_cnt = 0, err_cnt = 0;
  logic [3:0] last_dir = 4'b0;

  ps2_move_decoder #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .direction(direction), .start(start), .frame_err(frame_err));

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    if (direction != 4'b0) begin
      dir_cnt  = dir_cnt + 1;
      last_dir = direction;
      t_dir    = cyc;
    end
    if (start) st_cnt = st_cnt + 1;
    if (frame_err) err_cnt = err_cnt + 1;
    if (!$onehot0({direction, start})) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL onehot: direction=%b start=%b, required at most one high", direction, start);
    end
  end

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      PS2_DAT = f[i];
      repeat (HALF) @(negedge CLOCK_50);
      PS2_CLK = 1'b0;
      if (i == 10) t_stop = cyc;
      repeat (HALF) @(negedge CLOCK_50);
      PS2_CLK = 1'b1;
    end
    PS2_DAT = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit flip);
    send_bits({1'b1, ~(^b) ^ flip, b, 1'b0}, 11);
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge CLOCK_50);
    total = total + 3;
    if (direction !== 4'b0) begin bad++; $display("FAIL reset_dir: got %b want 0000", direction); end
    if (start !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", start); end
    if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", frame_err); end
    resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50);
  endtask

  task automatic test_up;
    int d0 = dir_cnt, s0 = st_cnt, e0 = err_cnt;
    send_byte(8'hE0, 0);
    send_byte(8'h75, 0);
    repeat (10) @(negedge CLOCK_50);
    total = total + 5;
    if (dir_cnt - d0 != 1) begin bad++; $display("FAIL up_count: got %0d want 1", dir_cnt - d0); end
    if (last_dir !== 4'b1000) begin bad++; $display("FAIL up_value: got %b want 1000", last_dir); end
    if (t_dir - t_stop != 3) begin bad++; $display("FAIL up_latency: got %0d want 3", t_dir - t_stop); end
    if (st_cnt != s0) begin bad++; $display("FAIL up_start: got %0d want 0", st_cnt - s0); end
    if (err_cnt != e0) begin bad++; $display("FAIL up_err: got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_typematic;
    int d0 = dir_cnt;
    send_byte(8'hE0, 0); send_byte(8'h6B, 0);
    total = total + 1;
    if (dir_cnt - d0 != 1) begin bad++; $display("FAIL left_first: got %0d want 1", dir_cnt - d0); end
    send_byte(8'hE0, 0); send_byte(8'h6B, 0);
    send_byte(8'hE0, 0); send_byte(8'h6B, 0);
    total = total + 1;
    if (dir_cnt - d0 != 1) begin bad++; $display("FAIL left_repeat: got %0d want 1", dir_cnt - d0); end
    send_byte(8'hE0, 0); send_byte(8'hF0, 0); send_byte(8'h6B, 0);
    send_byte(8'hE0, 0); send_byte(8'h6B, 0);
    repeat (10) @(negedge CLOCK_50);
    total = total + 3;
    if (dir_cnt - d0 != 2) begin bad++; $display("FAIL left_total: got %0d want 2", dir_cnt - d0); end
    if (last_dir !== 4'b0010) begin bad++; $display("FAIL left_value: got %b want 0010", last_dir); end
    if (t_dir - t_stop != 3) begin bad++; $display("FAIL left_latency: got %0d want 3", t_dir - t_stop); end
  endtask

  task automatic test_start;
    int d0 = dir_cnt, s0 = st_cnt;
    send_byte(8'h1B, 0);
    send_byte(8'hF0, 0); send_byte(8'h1B, 0);
    send_byte(8'h75, 0);
    repeat (10) @(negedge CLOCK_50);
    total = total + 2;
    if (st_cnt - s0 != 1) begin bad++; $display("FAIL start_count: got %0d want 1", st_cnt - s0); end
    if (dir_cnt != d0) begin bad++; $display("FAIL keypad_ignored: got %0d want 0", dir_cnt - d0); end
    send_byte(8'h1B, 0);
    repeat (10) @(negedge CLOCK_50);
    total = total + 1;
    if (st_cnt - s0 != 2) begin bad++; $display("FAIL start_repress: got %0d want 2", st_cnt - s0); end
    send_byte(8'hF0, 0); send_byte(8'h1B, 0);
  endtask

  task automatic test_parity;
    int s0 = st_cnt, e0 = err_cnt;
    send_byte(8'h1B, 1);
    repeat (10) @(negedge CLOCK_50);
    total = total + 2;
`ifdef PS2_PARITY_CHECK_EN
    if (err_cnt - e0 != 1) begin bad++; $display("FAIL parity_err: got %0d want 1", err_cnt - e0); end
    if (st_cnt != s0) begin bad++; $display("FAIL parity_start: got %0d want 0", st_cnt - s0); end
`else
    if (err_cnt != e0) begin bad++; $display("FAIL parity_err: got %0d want 0", err_cnt - e0); end
    if (st_cnt - s0 != 1) begin bad++; $display("FAIL parity_start: got %0d want 1", st_cnt - s0); end
`endif
    send_byte(8'hF0, 0); send_byte(8'h1B, 0);
  endtask

  task automatic test_timeout;
    int d0 = dir_cnt, e0 = err_cnt;
    send_byte(8'hE0, 0);
    send_bits({1'b1, 1'b1, 8'h74, 1'b0}, 5);
    repeat (TO / 2) @(negedge CLOCK_50);
    total = total + 1;
    if (err_cnt != e0) begin bad++; $display("FAIL timeout_early: got %0d want 0", err_cnt - e0); end
    repeat (TO / 2 + 20) @(negedge CLOCK_50);
    total = total + 1;
    if (err_cnt - e0 != 1) begin bad++; $display("FAIL timeout_err: got %0d want 1", err_cnt - e0); end
    send_byte(8'h74, 0);
    repeat (10) @(negedge CLOCK_50);
    total = total + 1;
    if (dir_cnt != d0) begin bad++; $display("FAIL timeout_ext_cleared: got %0d want 0", dir_cnt - d0); end
    send_byte(8'hE0, 0); send_byte(8'h74, 0);
    repeat (10) @(negedge CLOCK_50);
    total = total + 3;
    if (dir_cnt - d0 != 1) begin bad++; $display("FAIL right_count: got %0d want 1", dir_cnt - d0); end
    if (last_dir !== 4'b0001) begin bad++; $display("FAIL right_value: got %b want 0001", last_dir); end
    if (err_cnt - e0 != 1) begin bad++; $display("FAIL timeout_err_once: got %0d want 1", err_cnt - e0); end
  endtask

  task automatic test_reset_mid;
    int d0;
    send_byte(8'hE0, 0);
    resetn = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    total = total + 1;
    if ({direction, start, frame_err} !== 6'b0) begin
      bad++; $display("FAIL midreset_outputs: got %b want 000000", {direction, start, frame_err});
    end
    resetn = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    d0 = dir_cnt;
    send_byte(8'h72, 0);
    repeat (10) @(negedge CLOCK_50);
    total = total + 1;
    if (dir_cnt != d0) begin bad++; $display("FAIL midreset_noext: got %0d want 0", dir_cnt - d0); end
    send_byte(8'hE0, 0); send_byte(8'h72, 0);
    repeat (10) @(negedge CLOCK_50);
    total = total + 2;
    if (dir_cnt - d0 != 1) begin bad++; $display("FAIL down_count: got %0d want 1", dir_cnt - d0); end
    if (last_dir !== 4'b0100) begin bad++; $display("FAIL down_value: got %b want 0100", last_dir); end
    send_byte(8'hE0, 0); send_byte(8'h74, 0);
    repeat (10) @(negedge CLOCK_50);
    total = total + 2;
    if (dir_cnt - d0 != 2) begin bad++; $display("FAIL held_cleared: got %0d want 2", dir_cnt - d0); end
    if (last_dir !== 4'b0001) begin bad++; $display("FAIL held_value: got %b want 0001", last_dir); end
  endtask

  initial begin
    test_reset;
    test_up;
    test_typematic;
    test_start;
    test_parity;
    test_timeout;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
